// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder: one shared single-digit BCD stage, LSD first, carry kept in a register.
// Optional macro BCD_OPERAND_CHECK_EN adds the err output flagging non-BCD operand digits at accept.
module bcd_serial_add_ctrl #(
  parameter int N_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*N_DIGITS-1:0] a,
  input  logic [4*N_DIGITS-1:0] b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*N_DIGITS-1:0] sum,
  output logic                  cout
`ifdef BCD_OPERAND_CHECK_EN
  ,
  output logic                  err
`endif
);

  localparam int W  = 4 * N_DIGITS;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Handshake: start is taken only in IDLE; done is a one-cycle pulse during
  // which sum/cout are valid, and they keep holding until the next accept.
  state_t          state_q, state_d;
  logic [W-1:0]    a_q, b_q, sum_q;
  logic [IW-1:0]   idx_q;
  logic            carry_q, cout_q;
  logic [3:0]      a_dig, b_dig, dig;
  logic [4:0]      t;
  logic            dig_carry;
  logic            last;

  assign a_dig = a_q[idx_q*4 +: 4];
  assign b_dig = b_q[idx_q*4 +: 4];
  assign last  = (idx_q == IW'(N_DIGITS - 1));

  // Single-digit BCD stage; non-BCD inputs follow the same correction rule.
  always_comb begin
    t         = 5'(a_dig) + 5'(b_dig) + 5'(carry_q);
    dig       = t[3:0];
    dig_carry = 1'b0;
    if (t > 5'd9) begin
      dig       = 4'(t + 5'd6);
      dig_carry = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
          end
        end
        RUN: begin
          sum_q[idx_q*4 +: 4] <= dig;
          carry_q             <= dig_carry;
          if (last) cout_q <= dig_carry;
          else      idx_q  <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef BCD_OPERAND_CHECK_EN
  function automatic logic has_non_bcd(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  logic err_q;

  always_ff @(posedge clk) begin
    if (rst)                           err_q <= 1'b0;
    else if (state_q == IDLE && start) err_q <= has_non_bcd(a) | has_non_bcd(b);
  end

  assign err = err_q;
`endif

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Bench for bcd_serial_add_ctrl: directed and random BCD additions checked against a decimal-arithmetic model.
// Checks err as well when BCD_OPERAND_CHECK_EN is defined.
module tb_bcd_serial_add_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst, start, cin;
  logic [W-1:0] a, b;
  logic         busy, done, cout;
  logic [W-1:0] sum;
`ifdef BCD_OPERAND_CHECK_EN
  logic         err;
`endif

  int checks   = 0;
  int failures = 0;
  logic [W:0] exp_q[$];

  bcd_serial_add_ctrl #(.N_DIGITS(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef BCD_OPERAND_CHECK_EN
    ,
    .err   (err)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain decimal arithmetic on the operand values
  function automatic longint bcd_val(input logic [W-1:0] v);
    longint r;
    r = 0;
    for (int i = N - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    longint       s, lim;
    logic         c;
    logic [W-1:0] r;
    lim = 1;
    for (int i = 0; i < N; i++) lim = lim * 10;
    s = bcd_val(av) + bcd_val(bv) + longint'(cv);
    c = (s >= lim);
    s = s % lim;
    r = '0;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'(s % 10);
      s = s / 10;
    end
    return {c, r};
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    for (int i = 0; i < N; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // Driver: issue one operation, optionally poke start during RUN, and score the result
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        input bit inject, input string tag);
    logic [W:0] exp;
    int lat;
    int extra_dones;
    exp_q.push_back(model(av, bv, cv));
    @(negedge clk);
    a = av; b = bv; cin = cv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    check({tag, "_busy_run"}, 64'(busy), 64'd1);
    check({tag, "_sum_cleared"}, 64'(sum), 64'd0);
    lat = 0;
    while (!done && lat < 3 * N + 4) begin
      start = (inject && lat == 1);
      if (inject && lat == 1) begin
        a = rand_bcd(); b = rand_bcd();
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    exp = exp_q.pop_front();
    check({tag, "_latency"}, 64'(lat), 64'(N));
    check({tag, "_sum"}, 64'(sum), 64'(exp[W-1:0]));
    check({tag, "_cout"}, 64'(cout), 64'(exp[W]));
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_busy_idle"}, 64'(busy), 64'd0);
    check({tag, "_sum_hold"}, 64'(sum), 64'(exp[W-1:0]));
    if (inject) begin
      extra_dones = 0;
      repeat (2 * N) begin
        @(negedge clk);
        if (done) extra_dones++;
      end
      check({tag, "_no_extra_done"}, 64'(extra_dones), 64'd0);
    end
  endtask

  task automatic mid_run_reset();
    int dones;
    @(negedge clk);
    a = 16'h1111; b = 16'h1111; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_partial_sum", 64'(sum), 64'h0022);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_sum", 64'(sum), 64'd0);
    check("rst_mid_cout", 64'(cout), 64'd0);
    rst = 1'b0;
    dones = 0;
    repeat (2 * N + 2) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("rst_mid_no_done", 64'(dones), 64'd0);
  endtask

`ifdef BCD_OPERAND_CHECK_EN
  task automatic err_test();
    int lat;
    @(negedge clk);
    a = 16'h12A4; b = 16'h0001; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("err_set", 64'(err), 64'd1);
    lat = 0;
    while (!done && lat < 3 * N + 4) begin
      @(negedge clk);
      lat++;
    end
    check("err_done_pulses", 64'(done), 64'd1);
    check("err_hold", 64'(err), 64'd1);
    @(negedge clk);
    run_op(16'h0042, 16'h0007, 1'b0, 1'b0, "err_valid");
    check("err_clear", 64'(err), 64'd0);
  endtask
`endif

  initial begin
    a = '0; b = '0; cin = 1'b0;
    do_reset();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_sum", 64'(sum), 64'd0);
    check("reset_cout", 64'(cout), 64'd0);
`ifdef BCD_OPERAND_CHECK_EN
    check("reset_err", 64'(err), 64'd0);
`endif

    run_op(16'h1234, 16'h5678, 1'b0, 1'b0, "basic");
    run_op(16'h9999, 16'h0001, 1'b0, 1'b0, "ripple");
    run_op(16'h0000, 16'h0000, 1'b1, 1'b0, "cin_only");
    run_op(16'h4999, 16'h5000, 1'b1, 1'b0, "cin_ripple");
    run_op(16'h9999, 16'h9999, 1'b1, 1'b0, "max");
    run_op(16'h2468, 16'h1357, 1'b0, 1'b1, "start_in_run");
    mid_run_reset();
    run_op(16'h0505, 16'h0505, 1'b0, 1'b0, "after_rst");
`ifdef BCD_OPERAND_CHECK_EN
    err_test();
`endif

    for (int i = 0; i < 24; i++) begin
      run_op(rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)), 1'b0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
